cfg_reg_arb: RTL and testbench
==============================

CFG_REG_ARB -- requirements
Module: cfg_reg_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports (fixed at 4 in this revision).
REQ-002 Parameter DATA_W, default 4, width of each shared register and of all data buses.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NUM_REQ  per-requester access request, level, held until own ack.
REQ-007 we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-008 addr  input  NUM_REQ*2  per-requester register index, packed, slice i at [2i+1:2i].
REQ-009 wdata  input  NUM_REQ*DATA_W  per-requester write data, packed.
REQ-010 gnt  output  NUM_REQ  one-hot grant, registered.
REQ-011 ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 rdata  output  DATA_W  read data, valid while ack is high.
REQ-013 err  output  1  protection violation flag, valid while ack is high.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 regs_o  output  4*DATA_W  live contents of reg3..reg0, packed with reg0 at [DATA_W-1:0].

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and RELEASE.
REQ-017 IDLE: if req is nonzero at a clock edge, the block SHALL load gnt with the round-robin winner and move to ACCESS; otherwise it SHALL stay in IDLE with gnt = 0.
REQ-018 Round robin: search starts at index last+1 modulo NUM_REQ; last is updated to the winner at each grant.
REQ-019 ACCESS: on the next edge, the block SHALL perform the winner's write (reg[addr] <= wdata) or capture rdata = reg[addr], assert ack for the winner and move to RELEASE.
REQ-020 RELEASE: ack and rdata SHALL be held for exactly this one cycle, gnt held; the block SHALL return to IDLE with gnt and ack cleared.
REQ-021 Latency: with req sampled at edge k, gnt is high after edge k and ack is high after edge k+1. A new grant is possible at edge k+3 at the earliest.
REQ-022 The requester SHALL drop req in the cycle ack is high. The arbiter SHALL ignore the just-served requester's req in IDLE only when ack was high on the preceding cycle; round robin then naturally deprioritises it.
REQ-023 A requester dropping req while granted SHALL NOT abort the access; the access completes using the inputs sampled at the ACCESS edge.
REQ-024 A read of an address written in the same ACCESS cycle cannot occur, because only one access runs at a time.
REQ-025 rdata SHALL be 0 whenever ack is zero.

Reset
REQ-026 On rst_n low, the block SHALL go to IDLE asynchronously and set gnt = 0, ack = 0, rdata = 0, err = 0, busy = 0 and last = NUM_REQ-1, so req[0] has first priority.
REQ-027 On rst_n low, registers SHALL reload the package reset values: reg0 = 5, reg1 = 6, reg2 = 7, reg3 = 8.
REQ-028 A reset during ACCESS or RELEASE SHALL abandon the access: no write is committed after the reset edge and no ack is issued.

Configuration
REQ-029 Macro CFG_REG_ARB_PROT_EN, when defined, SHALL allow requester i to write only register i. A violating write SHALL be discarded, but ack is still issued and err = 1 for that cycle. Reads are unrestricted.
REQ-030 Without CFG_REG_ARB_PROT_EN, all writes SHALL commit and err SHALL be tied to 0.

Structure
REQ-031 Package cfg_reg_pkg SHALL hold the NUM_REQ and DATA_W defaults, the reset constants REG0_RST..REG3_RST (5, 6, 7, 8) and typedef enum arb_state_t {IDLE, ACCESS, RELEASE}. The module SHALL import the package explicitly, with no wildcard import.
REQ-032 The round-robin winner logic SHALL be a sub-module rr_pick with inputs req and last and output a one-hot winner.

Verification
REQ-033 Reset check: release rst_n -> regs_o = 0x8765, gnt = 0, ack = 0, busy = 0.
REQ-034 Single read: req[2]=1, we[2]=0, addr[2]=1 at edge k -> gnt = 0100 after k; ack = 0100 and rdata = 6 after k+1; back in IDLE after k+3.
REQ-035 Write then read: requester 3 writes addr 3 with 0xA -> regs_o[15:12] = 0xA; requester 0 then reads addr 3 -> rdata = 0xA.
REQ-036 Contention: req = 1111 from reset, each requester dropping req on its ack -> grants in order 0001, 0010, 0100, 1000, spaced 3 cycles apart.
REQ-037 Protection: requester 1 writes addr 0 with 0xF -> with CFG_REG_ARB_PROT_EN: ack[1] = 1, err = 1, reg0 stays 5. Without the macro: reg0 = 0xF, err = 0.
REQ-038 Reset mid-write: assert rst_n low in ACCESS during a write of 0x3 to addr 2 -> reg2 = 7, ack never asserted, gnt = 0.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared constants, FSM state type and helper function for the cfg_reg_arb
// register arbiter.
package cfg_reg_pkg;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 4;
  localparam int IDX_W    = 2;
  localparam int NUM_REGS = 4;

  localparam int REG0_RST = 5;
  localparam int REG1_RST = 6;
  localparam int REG2_RST = 7;
  localparam int REG3_RST = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Convert a one-hot requester vector into its index (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cfg_reg_arb_rr_pick.sv
// rr_pick: round-robin winner selection. The search starts one past the
// last winner and wraps, so the most recently served requester has the
// lowest priority. NUM_REQ must be 2**IDX_W so the index wraps naturally.
module rr_pick #(
  parameter int NUM_REQ = cfg_reg_pkg::NUM_REQ,
  parameter int IDX_W   = cfg_reg_pkg::IDX_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner
);

  // First set request found scanning upward from last+1 wins.
  always_comb begin
    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    winner  = '0;
    w_found = 1'b0;
    w_idx   = {IDX_W{1'b0}};
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = last + IDX_W'(off);
      if (!w_found && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        w_found       = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/cfg_reg_arb.sv
// cfg_reg_arb: four requesters share four DATA_W-bit registers through a
// round-robin arbiter. Each access runs IDLE -> ACCESS -> RELEASE.
// Optional macro CFG_REG_ARB_PROT_EN: requester i may only write register i;
// violating writes are dropped and flagged on err alongside ack.
module cfg_reg_arb
  import cfg_reg_pkg::arb_state_t, cfg_reg_pkg::IDLE, cfg_reg_pkg::ACCESS,
         cfg_reg_pkg::RELEASE, cfg_reg_pkg::IDX_W, cfg_reg_pkg::NUM_REGS,
         cfg_reg_pkg::onehot_to_idx, cfg_reg_pkg::REG0_RST,
         cfg_reg_pkg::REG1_RST, cfg_reg_pkg::REG2_RST, cfg_reg_pkg::REG3_RST;
#(
  parameter int NUM_REQ = cfg_reg_pkg::NUM_REQ,
  parameter int DATA_W  = cfg_reg_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*2-1:0]       addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       err,
  output logic                       busy,
  output logic [4*DATA_W-1:0]        regs_o
);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_busy;
  logic [IDX_W-1:0]    r_last;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [NUM_REQ-1:0]  w_req_eff;
  logic [NUM_REQ-1:0]  w_winner;
  logic [NUM_REQ-1:0]  w_next_gnt;
  logic [NUM_REQ-1:0]  w_next_ack;
  logic [DATA_W-1:0]   w_next_rdata;
  logic                w_next_err;
  logic [IDX_W-1:0]    w_next_last;
  logic                w_wr_en;

  logic [1:0]          w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
  logic                w_sel_we;
  logic [1:0]          w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_viol;

  // Split the packed per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr_arr[i]  = addr[2*i +: 2];
      w_wdata_arr[i] = wdata[DATA_W*i +: DATA_W];
    end
  end

  // r_last holds the granted requester's index for the whole access.
  assign w_sel_we    = we[r_last];
  assign w_sel_addr  = w_addr_arr[r_last];
  assign w_sel_wdata = w_wdata_arr[r_last];

`ifdef CFG_REG_ARB_PROT_EN
  assign w_viol = w_sel_we && (w_sel_addr != r_last);
`else
  assign w_viol = 1'b0;
`endif

  // A requester still showing req while its ack is up is not re-arbitrated.
  assign w_req_eff = req & ~r_ack;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (w_req_eff),
    .last   (r_last),
    .winner (w_winner)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic: one access occupies ACCESS then RELEASE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (|w_req_eff) begin
          w_next_state = ACCESS;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCESS:  w_next_state = RELEASE;
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs and write strobe.
  always_comb begin
    w_next_gnt   = r_gnt;
    w_next_ack   = '0;
    w_next_rdata = '0;
    w_next_err   = 1'b0;
    w_next_last  = r_last;
    w_wr_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req_eff) begin
          w_next_gnt  = w_winner;
          w_next_last = onehot_to_idx(w_winner);
        end else begin
          w_next_gnt  = '0;
        end
      end
      ACCESS: begin
        w_next_ack = r_gnt;
        w_next_err = w_viol;
        if (w_sel_we) begin
          w_wr_en = !w_viol;
        end else begin
          w_next_rdata = r_regs[w_sel_addr];
        end
      end
      RELEASE: begin
        w_next_gnt = '0;
      end
      default: begin
        w_next_gnt = '0;
      end
    endcase
  end

  // Registered handshake outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_gnt   <= w_next_gnt;
      r_ack   <= w_next_ack;
      r_rdata <= w_next_rdata;
      r_err   <= w_next_err;
      r_busy  <= (w_next_state != IDLE);
      r_last  <= w_next_last;
    end
  end

  // Shared register file; a reset abandons any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs[0] <= DATA_W'(REG0_RST);
      r_regs[1] <= DATA_W'(REG1_RST);
      r_regs[2] <= DATA_W'(REG2_RST);
      r_regs[3] <= DATA_W'(REG3_RST);
    end else if (w_wr_en) begin
      r_regs[w_sel_addr] <= w_sel_wdata;
    end
  end

  assign gnt    = r_gnt;
  assign ack    = r_ack;
  assign rdata  = r_rdata;
  assign err    = r_err;
  assign busy   = r_busy;
  assign regs_o = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

endmodule

// File: tb/tb_cfg_reg_arb.sv
// Self-checking bench for cfg_reg_arb: directed scenarios plus randomized
// traffic compared against a transaction-level model kept in the bench.
module tb_cfg_reg_arb;

`ifdef CFG_REG_ARB_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  rdata;
  logic        err;
  logic        busy;
  logic [15:0] regs_o;

  always #5 clk = ~clk;

  cfg_reg_arb dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .rdata  (rdata),
    .err    (err),
    .busy   (busy),
    .regs_o (regs_o)
  );

  int checks = 0;
  int errors = 0;

  // per-requester stimulus
  int t_we[4];
  int t_addr[4];
  int t_wdata[4];

  // transaction-level model
  int m_regs[4];
  int m_last, m_win, m_start, m_n, m_rd, m_err;
  logic [3:0]  exp_gnt, exp_ack, exp_rdata;
  logic        exp_err, exp_busy;
  logic [15:0] exp_regs;

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      we[i]          = (t_we[i] != 0);
      addr[2*i +: 2] = 2'(t_addr[i]);
      wdata[4*i +: 4] = 4'(t_wdata[i]);
    end
  endtask

  task automatic model_reset();
    m_regs  = '{5, 6, 7, 8};
    m_last  = 3;
    m_win   = 0;
    m_start = m_n - 10;
    m_rd    = 0;
    m_err   = 0;
  endtask

  // Advance one clock edge; the model sees the inputs present at that edge.
  // A granted access performs its work one edge after the grant, and the
  // arbiter can grant again three edges after the previous grant.
  task automatic tick();
    int  d;
    int  a;
    bit  viol;
    bit  found;
    int  idx;
    pack();
    m_n++;
    d = m_n - m_start;
    if (d == 1) begin
      a     = t_addr[m_win];
      viol  = PROT && (a != m_win);
      m_err = viol;
      m_rd  = 0;
      if (t_we[m_win] != 0) begin
        if (!viol) m_regs[a] = t_wdata[m_win];
      end else begin
        m_rd = m_regs[a];
      end
    end else if (d >= 3 && req != 4'b0) begin
      found = 0;
      for (int off = 1; off <= 4; off++) begin
        idx = (m_last + off) % 4;
        if (!found && req[idx]) begin
          found   = 1;
          m_win   = idx;
          m_last  = idx;
          m_start = m_n;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    d = m_n - m_start;
    exp_gnt   = (d <= 1) ? 4'(1 << m_win) : 4'b0;
    exp_ack   = (d == 1) ? 4'(1 << m_win) : 4'b0;
    exp_rdata = (d == 1) ? 4'(m_rd) : 4'b0;
    exp_err   = (d == 1) ? (m_err != 0) : 1'b0;
    exp_busy  = (d <= 1);
    exp_regs  = {4'(m_regs[3]), 4'(m_regs[2]), 4'(m_regs[1]), 4'(m_regs[0])};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    for (int i = 0; i < 4; i++) begin
      t_we[i] = 0; t_addr[i] = 0; t_wdata[i] = 0;
    end
    pack();
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (regs_o !== 16'h8765) begin errors++; $display("FAIL reset_regs got %h exp 8765", regs_o); end
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    t_we[2] = 0; t_addr[2] = 1; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rd_gnt got %b exp 0100", gnt); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rd_ack_early got %b exp 0000", ack); end
    tick();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rd_ack got %b exp 0100", ack); end
    checks++; if (rdata !== 4'h6) begin errors++; $display("FAIL rd_data got %h exp 6", rdata); end
    req[2] = 1'b0;
    tick();
    checks++; if (ack !== 4'b0 || gnt !== 4'b0 || rdata !== 4'h0) begin
      errors++; $display("FAIL rd_release ack %b gnt %b rdata %h exp all 0", ack, gnt, rdata); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_write_read();
    t_we[3] = 1; t_addr[3] = 3; t_wdata[3] = 4'hA; req = 4'b1000;
    tick();
    tick();
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wr_ack got %b exp 1000", ack); end
    checks++; if (regs_o[15:12] !== 4'hA) begin errors++; $display("FAIL wr_reg3 got %h exp a", regs_o[15:12]); end
    req[3] = 1'b0;
    tick(); tick();
    t_we[0] = 0; t_addr[0] = 3; req = 4'b0001;
    tick();
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rb_ack got %b exp 0001", ack); end
    checks++; if (rdata !== 4'hA) begin errors++; $display("FAIL rb_data got %h exp a", rdata); end
    req[0] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_protection();
    t_we[1] = 1; t_addr[1] = 0; t_wdata[1] = 4'hF; req = 4'b0010;
    tick();
    tick();
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL prot_ack got %b exp 0010", ack); end
`ifdef CFG_REG_ARB_PROT_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL prot_err got %b exp 1", err); end
    checks++; if (regs_o[3:0] !== 4'h5) begin errors++; $display("FAIL prot_reg0 got %h exp 5", regs_o[3:0]); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL prot_err got %b exp 0", err); end
    checks++; if (regs_o[3:0] !== 4'hF) begin errors++; $display("FAIL prot_reg0 got %h exp f", regs_o[3:0]); end
`endif
    req[1] = 1'b0;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL prot_err_clear got %b exp 0", err); end
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] prev;
    logic [3:0] g_val[$];
    int         g_cyc[$];
    logic [3:0] exp_seq[4];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++) begin t_we[i] = 0; t_addr[i] = i; end
    req  = 4'b1111;
    prev = 4'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (gnt != 4'b0 && prev == 4'b0) begin g_val.push_back(gnt); g_cyc.push_back(c); end
      prev = gnt;
      for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
    end
    checks++; if (g_val.size() != 4) begin errors++; $display("FAIL cont_count got %0d exp 4", g_val.size()); end
    for (int i = 0; i < 4 && i < g_val.size(); i++) begin
      checks++; if (g_val[i] !== exp_seq[i]) begin errors++; $display("FAIL cont_gnt%0d got %b exp %b", i, g_val[i], exp_seq[i]); end
      if (i > 0) begin
        checks++; if (g_cyc[i] - g_cyc[i-1] != 3) begin
          errors++; $display("FAIL cont_space%0d got %0d exp 3", i, g_cyc[i] - g_cyc[i-1]); end
      end
    end
    req = 4'b0;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    t_we[2] = 1; t_addr[2] = 2; t_wdata[2] = 3; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt got %b exp 0100", gnt); end
    rst_n = 1'b0;
    req   = 4'b0;
    #1;
    checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_async gnt %b busy %b exp 0000 0", gnt, busy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (regs_o[11:8] !== 4'h7) begin errors++; $display("FAIL mid_reg2 got %h exp 7", regs_o[11:8]); end
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (ack !== 4'b0 || gnt !== 4'b0 || regs_o[11:8] !== 4'h7) begin
        errors++; $display("FAIL mid_after%0d ack %b gnt %b reg2 %h exp 0000 0000 7", c, ack, gnt, regs_o[11:8]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (gnt[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && !gnt[i] && $urandom_range(0, 2) == 0) begin
          req[i]     = 1'b1;
          t_we[i]    = int'($urandom_range(0, 1));
          t_addr[i]  = int'($urandom_range(0, 3));
          t_wdata[i] = int'($urandom_range(0, 15));
        end
      end
      tick();
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", c, gnt, exp_gnt); end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %b exp %b", c, ack, exp_ack); end
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", c, rdata, exp_rdata); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", c, err, exp_err); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy, exp_busy); end
      checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL rnd_regs cyc %0d got %h exp %h", c, regs_o, exp_regs); end
    end
    req = 4'b0;
  endtask

  initial begin
    m_n = 0;
    test_reset();
    test_single_read();
    test_write_read();
    test_protection();
    test_contention();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
